// File: rtl/uart_fifo_fwft.sv
// First-word-fall-through FIFO with level/threshold flags and sticky error flags.
// Define UART_FIFO_PARITY_EN to store an even-parity bit per entry and report head parity errors.
module uart_fifo_fwft #(
    parameter int FIFO_DW    = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic               i_clk,
    input  logic               i_nrst,
    input  logic               i_flush,
    input  logic               i_wr_req,
    input  logic [FIFO_DW-1:0] i_data_in,
    input  logic               i_par_inj,
    input  logic               i_rd_req,
    input  logic [CW-1:0]      i_afull_thr,
    input  logic [CW-1:0]      i_aempty_thr,
    input  logic               i_clr_err,
    output logic [FIFO_DW-1:0] o_data_out,
    output logic               o_valid,
    output logic [CW-1:0]      o_used,
    output logic [CW-1:0]      o_free,
    output logic               o_full,
    output logic               o_empty,
    output logic               o_almost_full,
    output logic               o_almost_empty,
    output logic               o_overflow,
    output logic               o_underflow,
    output logic               o_parity_error
);
    localparam int PW = $clog2(FIFO_DEPTH);
`ifdef UART_FIFO_PARITY_EN
    localparam int EW = FIFO_DW + 1;
`else
    localparam int EW = FIFO_DW;
`endif

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] used_reg, used_next, level_next;
    logic          overflow_reg, overflow_next, underflow_reg, underflow_next;
    logic          afull_reg, aempty_reg;
    logic          full, valid, push, pop;
    logic [EW-1:0] wr_entry, head;

    always_comb begin
        full           = (used_reg == CW'(FIFO_DEPTH));
        valid          = (used_reg != '0);
        pop            = i_rd_req & valid & ~i_flush;
        push           = i_wr_req & ~i_flush & (~full | pop);
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        used_next      = used_reg;
        if (i_flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            used_next   = '0;
        end else begin
            if (push)
                wr_ptr_next = (wr_ptr_reg == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_reg + PW'(1);
            if (pop)
                rd_ptr_next = (rd_ptr_reg == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_reg + PW'(1);
            if (push && !pop)
                used_next = used_reg + CW'(1);
            else if (pop && !push)
                used_next = used_reg - CW'(1);
        end
        // A fresh error event outranks a clear in the same cycle; flush never touches the flags.
        overflow_next  = (i_wr_req & full & ~pop & ~i_flush) | (overflow_reg & ~i_clr_err);
        underflow_next = (i_rd_req & ~valid & ~i_flush) | (underflow_reg & ~i_clr_err);
        level_next     = i_nrst ? used_next : '0;
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            used_reg      <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            used_reg      <= used_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    // Threshold flags keep tracking the thresholds (against level 0) while reset is held.
    always_ff @(posedge i_clk) begin
        afull_reg  <= (level_next >= i_afull_thr);
        aempty_reg <= (level_next <= i_aempty_thr);
    end

    always_ff @(posedge i_clk) begin
        if (push)
            mem[wr_ptr_reg] <= wr_entry;
    end

    assign head = mem[rd_ptr_reg];

`ifdef UART_FIFO_PARITY_EN
    assign wr_entry       = {(^i_data_in) ^ i_par_inj, i_data_in};
    assign o_parity_error = valid & ((^head[FIFO_DW-1:0]) != head[FIFO_DW]);
`else
    logic unused_par_inj;
    assign unused_par_inj = i_par_inj;
    assign wr_entry       = i_data_in;
    assign o_parity_error = 1'b0;
`endif

    assign o_data_out     = valid ? head[FIFO_DW-1:0] : '0;
    assign o_valid        = valid;
    assign o_used         = used_reg;
    assign o_free         = CW'(FIFO_DEPTH) - used_reg;
    assign o_full         = full;
    assign o_empty        = ~valid;
    assign o_almost_full  = afull_reg;
    assign o_almost_empty = aempty_reg;
    assign o_overflow     = overflow_reg;
    assign o_underflow    = underflow_reg;
endmodule

// File: tb/tb_uart_fifo_fwft.sv
// Bench for uart_fifo_fwft (depth 5): directed scenarios plus random traffic against a queue model.
module tb_uart_fifo_fwft;
    localparam int DW = 8;
    localparam int DEPTH = 5;
    localparam int CW = $clog2(DEPTH + 1);

    logic i_clk = 1'b0, i_nrst, i_flush, i_wr_req, i_par_inj, i_rd_req, i_clr_err;
    logic [DW-1:0] i_data_in, o_data_out;
    logic [CW-1:0] i_afull_thr, i_aempty_thr, o_used, o_free;
    logic o_valid, o_full, o_empty, o_almost_full, o_almost_empty;
    logic o_overflow, o_underflow, o_parity_error;

    int errors = 0;
    int checks = 0;
    logic [DW:0] m_q[$];   // {parity injected, data}
    bit m_ovf, m_unf;

    uart_fifo_fwft #(.FIFO_DW(DW), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_nrst(i_nrst), .i_flush(i_flush), .i_wr_req(i_wr_req),
        .i_data_in(i_data_in), .i_par_inj(i_par_inj), .i_rd_req(i_rd_req),
        .i_afull_thr(i_afull_thr), .i_aempty_thr(i_aempty_thr), .i_clr_err(i_clr_err),
        .o_data_out(o_data_out), .o_valid(o_valid), .o_used(o_used), .o_free(o_free),
        .o_full(o_full), .o_empty(o_empty), .o_almost_full(o_almost_full),
        .o_almost_empty(o_almost_empty), .o_overflow(o_overflow), .o_underflow(o_underflow),
        .o_parity_error(o_parity_error)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [DW-1:0] exp_data();
        return (m_q.size() != 0) ? m_q[0][DW-1:0] : '0;
    endfunction

    function automatic bit exp_perr();
`ifdef UART_FIFO_PARITY_EN
        return (m_q.size() != 0) && m_q[0][DW];
`else
        return 1'b0;
`endif
    endfunction

    // Drive one cycle of inputs, let the edge happen, and advance the model by the spec rules.
    task automatic cycle(input bit wr, input logic [DW-1:0] d, input bit inj,
                         input bit rd, input bit fl, input bit clr);
        bit full, valid, pop, push, ovf_ev, unf_ev;
        i_wr_req = wr; i_data_in = d; i_par_inj = inj; i_rd_req = rd; i_flush = fl; i_clr_err = clr;
        full   = (m_q.size() == DEPTH);
        valid  = (m_q.size() != 0);
        pop    = rd && valid && !fl;
        push   = wr && !fl && (!full || pop);
        ovf_ev = wr && full && !pop && !fl;
        unf_ev = rd && !valid && !fl;
        @(posedge i_clk);
        if (fl) m_q.delete();
        else begin
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back({inj, d});
        end
        m_ovf = ovf_ev || (m_ovf && !clr);
        m_unf = unf_ev || (m_unf && !clr);
        #1;
        i_wr_req = 0; i_rd_req = 0; i_flush = 0; i_clr_err = 0; i_par_inj = 0;
    endtask

    task automatic idle();
        cycle(0, '0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        i_nrst = 0; i_afull_thr = 0; i_aempty_thr = 2;
        repeat (2) @(posedge i_clk);
        #1;
        checks++; if (o_used !== 0) begin errors++; $display("FAIL reset_used got=%0d want=0", o_used); end
        checks++; if (o_free !== CW'(DEPTH)) begin errors++; $display("FAIL reset_free got=%0d want=%0d", o_free, DEPTH); end
        checks++; if (o_empty !== 1 || o_full !== 0) begin errors++; $display("FAIL reset_level got empty=%b full=%b want 1 0", o_empty, o_full); end
        checks++; if (o_valid !== 0 || o_data_out !== 0) begin errors++; $display("FAIL reset_head got valid=%b data=%h want 0 00", o_valid, o_data_out); end
        checks++; if (o_overflow !== 0 || o_underflow !== 0 || o_parity_error !== 0) begin errors++; $display("FAIL reset_errs got %b%b%b want 000", o_overflow, o_underflow, o_parity_error); end
        checks++; if (o_almost_full !== 1 || o_almost_empty !== 1) begin errors++; $display("FAIL reset_thr got af=%b ae=%b want 1 1", o_almost_full, o_almost_empty); end
        i_afull_thr = 3; i_aempty_thr = 0;
        @(posedge i_clk); #1;
        checks++; if (o_almost_full !== 0 || o_almost_empty !== 1) begin errors++; $display("FAIL reset_thr_chg got af=%b ae=%b want 0 1", o_almost_full, o_almost_empty); end
        i_nrst = 1; m_q.delete(); m_ovf = 0; m_unf = 0;
        i_aempty_thr = 1;
        idle();
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 5; i++) cycle(1, DW'(8'h11 + i), 0, 0, 0, 0);
        checks++; if (o_full !== 1 || o_used !== 5 || o_free !== 0) begin errors++; $display("FAIL fill_full got full=%b used=%0d free=%0d want 1 5 0", o_full, o_used, o_free); end
        cycle(1, 8'h16, 0, 0, 0, 0);
        checks++; if (o_overflow !== 1 || o_used !== 5) begin errors++; $display("FAIL fill_ovf got ovf=%b used=%0d want 1 5", o_overflow, o_used); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (o_data_out !== DW'(8'h11 + i)) begin errors++; $display("FAIL fill_order[%0d] got=%h want=%h", i, o_data_out, 8'h11 + i); end
            cycle(0, '0, 0, 1, 0, 0);
        end
        checks++; if (o_empty !== 1 || o_overflow !== 1) begin errors++; $display("FAIL fill_drain got empty=%b ovf=%b want 1 1", o_empty, o_overflow); end
        cycle(0, '0, 0, 0, 0, 1);
        checks++; if (o_overflow !== 0) begin errors++; $display("FAIL fill_clr got ovf=%b want 0", o_overflow); end
    endtask

    task automatic test_fwft();
        cycle(1, 8'hA5, 0, 0, 0, 0);
        checks++; if (o_valid !== 1 || o_data_out !== 8'hA5) begin errors++; $display("FAIL fwft_first got valid=%b data=%h want 1 a5", o_valid, o_data_out); end
        cycle(1, 8'h3C, 0, 1, 0, 0);
        checks++; if (o_data_out !== 8'h3C || o_used !== 1) begin errors++; $display("FAIL fwft_pushpop got data=%h used=%0d want 3c 1", o_data_out, o_used); end
        cycle(0, '0, 0, 1, 0, 0);
        checks++; if (o_valid !== 0 || o_underflow !== 0) begin errors++; $display("FAIL fwft_drain got valid=%b unf=%b want 0 0", o_valid, o_underflow); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < DEPTH; i++) cycle(1, DW'($urandom), 0, 0, 0, 0);
        for (int i = 0; i < 3 * DEPTH; i++) begin
            logic [DW-1:0] want;
            want = exp_data();
            checks++; if (o_data_out !== want) begin errors++; $display("FAIL b2b_head[%0d] got=%h want=%h", i, o_data_out, want); end
            cycle(1, DW'($urandom), 0, 1, 0, 0);
            checks++; if (o_overflow !== 0 || o_used !== CW'(DEPTH)) begin errors++; $display("FAIL b2b_level[%0d] got ovf=%b used=%0d want 0 %0d", i, o_overflow, o_used, DEPTH); end
        end
        for (int i = 0; i < DEPTH; i++) begin
            logic [DW-1:0] want;
            want = exp_data();
            checks++; if (o_data_out !== want) begin errors++; $display("FAIL b2b_drain[%0d] got=%h want=%h", i, o_data_out, want); end
            cycle(0, '0, 0, 1, 0, 0);
        end
    endtask

    task automatic test_thresholds();
        bit ae_tab[5] = '{1, 1, 0, 0, 0};
        bit af_tab[5] = '{0, 0, 0, 1, 1};
        i_afull_thr = 3; i_aempty_thr = 1;
        idle();
        for (int n = 0; n < 5; n++) begin
            checks++; if (o_almost_empty !== ae_tab[n] || o_almost_full !== af_tab[n]) begin errors++; $display("FAIL thr_used%0d got ae=%b af=%b want %b %b", n, o_almost_empty, o_almost_full, ae_tab[n], af_tab[n]); end
            if (n < 4) cycle(1, DW'(n), 0, 0, 0, 0);
        end
        cycle(0, '0, 0, 1, 0, 0);
        cycle(0, '0, 0, 1, 0, 0);
        checks++; if (o_almost_full !== 0 || o_used !== 2) begin errors++; $display("FAIL thr_at2 got af=%b used=%0d want 0 2", o_almost_full, o_used); end
        i_afull_thr = 2;
        idle();
        checks++; if (o_almost_full !== 1) begin errors++; $display("FAIL thr_change got af=%b want 1", o_almost_full); end
        i_afull_thr = 3;
        cycle(0, '0, 0, 1, 0, 0);
        cycle(0, '0, 0, 1, 0, 0);
    endtask

    task automatic test_underflow();
        cycle(0, '0, 0, 1, 0, 0);
        checks++; if (o_underflow !== 1) begin errors++; $display("FAIL unf_set got=%b want 1", o_underflow); end
        idle(); idle();
        checks++; if (o_underflow !== 1) begin errors++; $display("FAIL unf_hold got=%b want 1", o_underflow); end
        cycle(0, '0, 0, 1, 0, 1);
        checks++; if (o_underflow !== 1) begin errors++; $display("FAIL unf_clr_race got=%b want 1", o_underflow); end
        cycle(0, '0, 0, 0, 0, 1);
        checks++; if (o_underflow !== 0) begin errors++; $display("FAIL unf_clr got=%b want 0", o_underflow); end
        cycle(1, 8'h77, 0, 1, 0, 0);
        checks++; if (o_underflow !== 1 || o_valid !== 1 || o_data_out !== 8'h77 || o_used !== 1) begin errors++; $display("FAIL unf_push_empty got unf=%b valid=%b data=%h used=%0d want 1 1 77 1", o_underflow, o_valid, o_data_out, o_used); end
        cycle(0, '0, 0, 1, 0, 1);
    endtask

    task automatic test_flush();
        cycle(0, '0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, DW'(8'hC0 + i), 0, 0, 0, 0);
        cycle(1, 8'hEE, 0, 1, 1, 0);
        checks++; if (o_used !== 0 || o_valid !== 0 || o_free !== CW'(DEPTH)) begin errors++; $display("FAIL flush_level got used=%0d valid=%b free=%0d want 0 0 %0d", o_used, o_valid, o_free, DEPTH); end
        checks++; if (o_underflow !== 1 || o_overflow !== 0) begin errors++; $display("FAIL flush_errs got unf=%b ovf=%b want 1 0", o_underflow, o_overflow); end
        cycle(1, 8'h42, 0, 0, 0, 1);
        checks++; if (o_data_out !== 8'h42 || o_used !== 1) begin errors++; $display("FAIL flush_after got data=%h used=%0d want 42 1", o_data_out, o_used); end
        cycle(0, '0, 0, 1, 0, 0);
    endtask

    task automatic test_parity();
        cycle(1, 8'h5A, 1, 0, 0, 0);
        cycle(1, 8'h33, 0, 0, 0, 0);
`ifdef UART_FIFO_PARITY_EN
        checks++; if (o_parity_error !== 1) begin errors++; $display("FAIL par_inject got=%b want 1", o_parity_error); end
`else
        checks++; if (o_parity_error !== 0 || o_data_out !== 8'h5A) begin errors++; $display("FAIL par_disabled got perr=%b data=%h want 0 5a", o_parity_error, o_data_out); end
`endif
        cycle(0, '0, 0, 0, 1, 0);
        checks++; if (o_valid !== 0 || o_parity_error !== 0) begin errors++; $display("FAIL par_flush got valid=%b perr=%b want 0 0", o_valid, o_parity_error); end
        cycle(1, 8'h5A, 0, 0, 0, 0);
        checks++; if (o_parity_error !== 0) begin errors++; $display("FAIL par_clean got=%b want 0", o_parity_error); end
        cycle(0, '0, 0, 1, 0, 0);
    endtask

    task automatic test_reset_midop();
        for (int i = 0; i < 3; i++) cycle(1, DW'(8'h90 + i), 0, 0, 0, 0);
        #2 i_nrst = 0;
        #1;
        checks++; if (o_used !== 0 || o_valid !== 0 || o_data_out !== 0) begin errors++; $display("FAIL rst_async got used=%0d valid=%b data=%h want 0 0 00", o_used, o_valid, o_data_out); end
        @(posedge i_clk); #1;
        i_nrst = 1; m_q.delete(); m_ovf = 0; m_unf = 0;
        cycle(1, 8'h9C, 0, 0, 0, 0);
        checks++; if (o_data_out !== 8'h9C || o_used !== 1) begin errors++; $display("FAIL rst_first_push got data=%h used=%0d want 9c 1", o_data_out, o_used); end
        cycle(0, '0, 0, 1, 0, 0);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            int wp, rp;
            logic [DW-1:0] wd;
            bit we, af, ae;
            wp = (c < 200) ? 70 : 40;
            rp = (c < 200) ? 40 : 70;
            if ($urandom_range(99) < 5) i_afull_thr = CW'($urandom_range(DEPTH));
            if ($urandom_range(99) < 5) i_aempty_thr = CW'($urandom_range(DEPTH));
            cycle($urandom_range(99) < wp, DW'($urandom), 1'($urandom), $urandom_range(99) < rp,
                  $urandom_range(99) < 2, $urandom_range(99) < 5);
            wd = exp_data();
            we = (m_q.size() != 0);
            af = (m_q.size() >= int'(i_afull_thr));
            ae = (m_q.size() <= int'(i_aempty_thr));
            checks++; if (o_data_out !== wd) begin errors++; $display("FAIL rnd_data[%0d] got=%h want=%h", c, o_data_out, wd); end
            checks++; if (o_valid !== we || o_empty !== !we) begin errors++; $display("FAIL rnd_valid[%0d] got v=%b e=%b want v=%b", c, o_valid, o_empty, we); end
            checks++; if (o_used !== CW'(m_q.size()) || o_free !== CW'(DEPTH - m_q.size())) begin errors++; $display("FAIL rnd_level[%0d] got used=%0d free=%0d want used=%0d", c, o_used, o_free, m_q.size()); end
            checks++; if (o_full !== (m_q.size() == DEPTH)) begin errors++; $display("FAIL rnd_full[%0d] got=%b want=%b", c, o_full, m_q.size() == DEPTH); end
            checks++; if (o_almost_full !== af || o_almost_empty !== ae) begin errors++; $display("FAIL rnd_thr[%0d] got af=%b ae=%b want %b %b", c, o_almost_full, o_almost_empty, af, ae); end
            checks++; if (o_overflow !== m_ovf || o_underflow !== m_unf) begin errors++; $display("FAIL rnd_errs[%0d] got ovf=%b unf=%b want %b %b", c, o_overflow, o_underflow, m_ovf, m_unf); end
            checks++; if (o_parity_error !== exp_perr()) begin errors++; $display("FAIL rnd_perr[%0d] got=%b want=%b", c, o_parity_error, exp_perr()); end
        end
    endtask

    initial begin
        i_nrst = 0; i_flush = 0; i_wr_req = 0; i_rd_req = 0; i_par_inj = 0; i_clr_err = 0;
        i_data_in = '0; i_afull_thr = '0; i_aempty_thr = '0;
        test_reset();
        test_fill_overflow();
        test_fwft();
        test_back_to_back();
        test_thresholds();
        test_underflow();
        test_flush();
        test_parity();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_fifo_fwft.md
UART_FIFO_FWFT -- requirements
Module: uart_fifo_fwft

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- FIFO_DW, 8, data word width in bits; must be 1 or more.
- FIFO_DEPTH, 16, number of entries; any value of 2 or more, not restricted to powers of two.
- CW, $clog2(FIFO_DEPTH+1), derived width of the level and threshold fields.

REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- i_clk, in, 1, the single clock; all logic is on its rising edge.
- i_nrst, in, 1, reset, asynchronous and active-low.
- i_flush, in, 1, synchronous empty command.
- i_wr_req, in, 1, push request.
- i_data_in, in, FIFO_DW, push data.
- i_par_inj, in, 1, invert the stored parity of this push (test aid).
- i_rd_req, in, 1, pop request.
- i_afull_thr, in, CW, almost-full threshold.
- i_aempty_thr, in, CW, almost-empty threshold.
- i_clr_err, in, 1, clears the sticky error flags.
- o_data_out, out, FIFO_DW, oldest word (first-word-fall-through).
- o_valid, out, 1, o_data_out holds a word.
- o_used, out, CW, number of stored words.
- o_free, out, CW, FIFO_DEPTH - o_used.
- o_full, o_empty, out, 1 each, level flags.
- o_almost_full, o_almost_empty, out, 1 each, threshold flags.
- o_overflow, o_underflow, out, 1 each, sticky error flags.
- o_parity_error, out, 1, the head word fails its parity check.

Function
REQ-003 Level, flag, count and data outputs SHALL be registered or derived from registers only, with no combinational path from any input.
REQ-004 A push is accepted iff i_wr_req, !i_flush, and either !o_full or an accepted pop in the same cycle.
REQ-005 A pop is accepted iff i_rd_req, o_valid and !i_flush.
REQ-006 o_valid SHALL equal (o_used != 0); a word pushed into an empty FIFO appears on o_data_out with o_valid=1 in the next cycle.
REQ-007 o_data_out SHALL show the oldest stored word and advance to the next word in the cycle after an accepted pop.
REQ-008 Read and write pointers SHALL wrap from FIFO_DEPTH-1 to 0.
REQ-009 o_used SHALL change as follows on an accepted operation: +1 for a push only, -1 for a pop only, unchanged for both together; it never exceeds FIFO_DEPTH.
REQ-010 o_full = (o_used == FIFO_DEPTH); o_empty = (o_used == 0).
REQ-011 o_almost_full = (o_used >= i_afull_thr); o_almost_empty = (o_used <= i_aempty_thr).
REQ-012 The threshold flags SHALL be updated every cycle, so a change in either threshold takes effect without any push or pop.
REQ-013 o_overflow SHALL set on i_wr_req while full without a simultaneous accepted pop.
REQ-014 o_underflow SHALL set on i_rd_req while !o_valid.
REQ-015 A push into an empty FIFO together with a read request SHALL accept the push and set o_underflow.
REQ-016 The error flags SHALL hold until a cycle with i_clr_err; a new error event in the same cycle as i_clr_err wins and leaves the flag set.
REQ-017 i_flush SHALL zero the pointers and o_used in the next cycle, ignore i_wr_req and i_rd_req in its cycle, and leave o_overflow and o_underflow unchanged.
REQ-018 Memory contents need not be cleared by reset or flush.

Reset
REQ-019 On i_nrst low, asynchronously: pointers=0, o_used=0, o_free=FIFO_DEPTH, o_empty=1, o_full=0, o_valid=0, o_data_out=0, o_overflow=0, o_underflow=0, o_parity_error=0.
REQ-020 o_almost_full and o_almost_empty SHALL reflect the current thresholds against o_used=0 while reset is held.
REQ-021 Assertion of reset mid-operation SHALL discard all stored words; the first push after release behaves as a push into an empty FIFO.

Configuration
REQ-022 With macro UART_FIFO_PARITY_EN defined, each entry SHALL be FIFO_DW+1 bits: data plus even parity, with the parity bit inverted when i_par_inj=1.
REQ-023 With UART_FIFO_PARITY_EN defined, o_parity_error = o_valid AND (the head word's recomputed parity does not match its stored parity).
REQ-024 Without UART_FIFO_PARITY_EN, entries SHALL be FIFO_DW bits, i_par_inj is ignored, and o_parity_error is tied to 0.

Verification
REQ-025 FIFO_DEPTH=5, push 0x11..0x15 -> o_full=1, o_used=5; 6th push -> o_overflow=1, o_used=5; pops return 0x11..0x15 in order.
REQ-026 Empty FIFO, push 0xA5 -> next cycle o_valid=1, o_data_out=0xA5; pop with simultaneous push of 0x3C -> o_data_out=0x3C, o_used stays 1.
REQ-027 Full FIFO with simultaneous push and pop -> both accepted, no overflow; run 3*FIFO_DEPTH such cycles and confirm data order across pointer wrap.
REQ-028 i_afull_thr=3, i_aempty_thr=1: o_used 0..4 gives almost_empty=1,1,0,0,0 and almost_full=0,0,0,1,1; changing i_afull_thr to 2 at o_used=2 sets almost_full in the next cycle.
REQ-029 Pop on empty -> o_underflow=1 held until i_clr_err; i_clr_err with a simultaneous bad pop -> o_underflow stays 1.
REQ-030 With UART_FIFO_PARITY_EN, push 0x5A with i_par_inj=1 -> o_parity_error=1 while that word is at the head; a following i_flush -> o_valid=0 and o_parity_error=0.
